uart_rx_par_chk: RTL and testbench
==================================

Name: uart_rx_par_chk

Overview:
- Receive-side companion to the UART TX parity generator.
- Takes mid-bit samples from the RX sampler/FSM and deserializes OP_WIDTH data bits, LSB first, into a holding register.
- Accumulates parity while shifting, then checks the received parity bit against the even/odd rule.
- Reports a clean frame (data_valid) or a parity failure (par_err) to the RX top and the system-control block.

Parameters:
- OP_WIDTH, 8, number of data bits per frame (valid range 5..9).

Ports:
- CLK  input  1  RX clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: start bit validated by RX FSM; begins a frame.
- sampled_bit  input  1  current majority-voted bit value.
- bit_strb  input  1  one-cycle pulse: sampled_bit is valid for the current bit slot.
- PAR_EN  input  1  1 = frame carries a parity bit; latched on accepted start.
- PAR_TYP  input  1  0 = even, 1 = odd; latched on accepted start.
- P_DATA  output  OP_WIDTH  received data word; holds until next completed frame.
- data_valid  output  1  one-cycle pulse: frame done, parity ok or parity disabled.
- par_err  output  1  one-cycle pulse: parity mismatch.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (RST=1 at clock edge) forces the following: state IDLE; P_DATA=0; data_valid=0; par_err=0; busy=0; shift register, bit counter and parity accumulator cleared. Reset mid-frame discards the partial frame with no pulses.
- States: IDLE, DATA, PARITY, DONE.
- IDLE:
  - bit_strb is ignored.
  - start=1: latch PAR_EN/PAR_TYP, clear counter and accumulator, go to DATA.
- DATA:
  - Each bit_strb shifts sampled_bit into the MSB of the shift register (shift right, LSB-first), XORs it into the accumulator and increments the counter.
  - On the strobe that completes bit OP_WIDTH-1: go to PARITY if latched PAR_EN=1, else DONE.
  - Cycles without bit_strb hold state.
- PARITY:
  - Expected bit = accumulator (even) or ~accumulator (odd).
  - On bit_strb: register mismatch = (sampled_bit != expected), then go to DONE.
- DONE (exactly one cycle):
  - P_DATA <= shift register.
  - data_valid = ~mismatch; par_err = mismatch; the two are mutually exclusive.
  - With parity disabled, mismatch is 0.
  - Next state is IDLE.
- Latency: data_valid/par_err are registered and asserted in the cycle after the final strobe (parity strobe, or last data strobe when PAR_EN=0).
- start while busy=1 (including DONE) is ignored. The frame in progress continues; the RX FSM must not issue start before the stop bit.
- start and bit_strb in the same IDLE cycle: start is accepted, the strobe is dropped.
- PAR_EN/PAR_TYP changes mid-frame have no effect; only the latched copies are used.
- Counter width is $clog2(OP_WIDTH+1); no wrap occurs because the FSM leaves DATA at OP_WIDTH.

Optional Feature:
- Macro: UART_RX_PAR_ERR_CNT_EN.
- Defined:
  - Adds input err_cnt_clr (1 bit) and output par_err_cnt (8 bits).
  - The counter increments in each DONE cycle with par_err=1 and saturates at 8'hFF.
  - err_cnt_clr and RST clear it to 0; clear wins over a simultaneous increment.
- Undefined: both ports and the counter are absent; all other behaviour is identical.

Decomposition:
- Package uart_rx_pkg holds:
  - state encoding (IDLE=2'b00, DATA=2'b01, PARITY=2'b10, DONE=2'b11);
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - DEF_OP_WIDTH=8;
  - ERR_CNT_W=8.
- One natural sub-module, rx_par_acc: a shift register plus XOR accumulator with clear/shift controls. The FSM, compare logic and output registers stay in uart_rx_par_chk.

Test Plan:
- Even parity, 8'hA5: start, strobes 1,0,1,0,0,1,0,1, parity bit 0 -> one cycle after the parity strobe, data_valid=1, par_err=0, P_DATA=8'hA5.
- Odd parity, 8'hA5, parity bit 0 (expected 1) -> par_err=1 for one cycle, data_valid=0, P_DATA=8'hA5.
- PAR_EN=0, 8'h3C -> data_valid pulses one cycle after the 8th strobe; a 9th strobe is ignored and busy=0.
- Reset after 4 data strobes -> no pulses, busy=0, P_DATA=0. Next frame 8'hFF with even parity bit 0 -> data_valid=1, P_DATA=8'hFF.
- start re-pulsed during DATA, and PAR_TYP toggled mid-frame -> no restart. Frame 8'h01 with latched even parity, parity bit 1 -> data_valid=1.
- With UART_RX_PAR_ERR_CNT_EN: 300 bad-parity frames -> par_err_cnt=8'hFF. Then err_cnt_clr in the same cycle as a par_err -> par_err_cnt=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive parity checker.
// Optional build macro: UART_RX_PAR_ERR_CNT_EN (adds a saturating parity-error counter).
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam int   DEF_OP_WIDTH = 8;
    localparam int   ERR_CNT_W    = 8;

endpackage

// File: rtl/rx_par_acc.sv
// LSB-first deserializer with running XOR parity and a received-bit counter.
// Optional build macro: none.
module rx_par_acc
    import uart_rx_pkg::*;
#(
    parameter  int OP_WIDTH = DEF_OP_WIDTH,
    localparam int CNT_W    = $clog2(OP_WIDTH + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clr,
    input  logic                shift,
    input  logic                bit_in,
    output logic [OP_WIDTH-1:0] shreg,
    output logic [OP_WIDTH-1:0] shreg_nxt,
    output logic                acc,
    output logic [CNT_W-1:0]    cnt
);

    // Value the shift register takes on the next shift; lets the owner capture
    // a complete word on the same edge as the last data bit.
    assign shreg_nxt = {bit_in, shreg[OP_WIDTH-1:1]};

    // Shift register, parity accumulator and bit counter.
    // NOTE: non-blocking assignments only in clocked blocks, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg <= '0;
            acc   <= 1'b0;
            cnt   <= '0;
        end else if (clr) begin
            acc   <= 1'b0;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= shreg_nxt;
            acc   <= acc ^ bit_in;
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_par_chk.sv
// UART receive data deserializer and parity checker.
// Optional build macro: UART_RX_PAR_ERR_CNT_EN (adds err_cnt_clr / par_err_cnt).
module uart_rx_par_chk
    import uart_rx_pkg::*;
#(
    parameter int OP_WIDTH = DEF_OP_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 sampled_bit,
    input  logic                 bit_strb,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    output logic [OP_WIDTH-1:0]  P_DATA,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 busy
`ifdef UART_RX_PAR_ERR_CNT_EN
    ,
    input  logic                 err_cnt_clr,
    output logic [ERR_CNT_W-1:0] par_err_cnt
`endif
);

    localparam int CNT_W = $clog2(OP_WIDTH + 1);

    state_t              state;
    state_t              next_state;
    logic                par_en_q;
    logic                par_typ_q;
    logic                acc_clr;
    logic                acc_shift;
    logic [OP_WIDTH-1:0] shreg;
    logic [OP_WIDTH-1:0] shreg_nxt;
    logic                acc;
    logic [CNT_W-1:0]    cnt;
    logic                last_data;
    logic                par_exp;
    logic                mismatch;

    rx_par_acc #(.OP_WIDTH(OP_WIDTH)) u_acc (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (acc_clr),
        .shift     (acc_shift),
        .bit_in    (sampled_bit),
        .shreg     (shreg),
        .shreg_nxt (shreg_nxt),
        .acc       (acc),
        .cnt       (cnt)
    );

    // The strobe that carries the final data bit of the frame.
    assign last_data = (state == ST_DATA) && bit_strb && (cnt == CNT_W'(OP_WIDTH - 1));
    assign par_exp   = (par_typ_q == PAR_ODD) ? ~acc : acc;
    assign mismatch  = (sampled_bit != par_exp);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; start is only honoured from IDLE.
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_DATA;
            ST_DATA:   if (last_data) next_state = par_en_q ? ST_PARITY : ST_DONE;
            ST_PARITY: if (bit_strb) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // State-decoded controls for the datapath and the busy flag.
    always_comb begin
        busy      = (state != ST_IDLE);
        acc_clr   = (state == ST_IDLE) && start;
        acc_shift = (state == ST_DATA) && bit_strb;
    end

    // Latched frame configuration and result registers. The result is captured
    // on the final strobe so it is visible for exactly the DONE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            if (acc_clr) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
            if (last_data && !par_en_q) begin
                P_DATA     <= shreg_nxt;
                data_valid <= 1'b1;
            end
            if ((state == ST_PARITY) && bit_strb) begin
                P_DATA     <= shreg;
                data_valid <= ~mismatch;
                par_err    <= mismatch;
            end
        end
    end

`ifdef UART_RX_PAR_ERR_CNT_EN
    // Saturating parity-error counter; a clear beats a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (RST || err_cnt_clr) begin
            par_err_cnt <= '0;
        end else if ((state == ST_DONE) && par_err && (par_err_cnt != '1)) begin
            par_err_cnt <= par_err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_par_chk.sv
// Self-checking bench for uart_rx_par_chk (OP_WIDTH = 8).
// Optional build macro: UART_RX_PAR_ERR_CNT_EN (enables the error-counter sequence).
module tb_uart_rx_par_chk;
    import uart_rx_pkg::*;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic         sampled_bit;
    logic         bit_strb;
    logic         PAR_EN;
    logic         PAR_TYP;
    logic [W-1:0] P_DATA;
    logic         data_valid;
    logic         par_err;
    logic         busy;
`ifdef UART_RX_PAR_ERR_CNT_EN
    logic                 err_cnt_clr;
    logic [ERR_CNT_W-1:0] par_err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       par_bit;
        logic       exp_valid;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    always #5 CLK = ~CLK;

    uart_rx_par_chk #(.OP_WIDTH(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .sampled_bit (sampled_bit),
        .bit_strb    (bit_strb),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .busy        (busy)
`ifdef UART_RX_PAR_ERR_CNT_EN
        ,
        .err_cnt_clr (err_cnt_clr),
        .par_err_cnt (par_err_cnt)
`endif
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic strobe(input logic b);
        @(negedge CLK);
        sampled_bit = b;
        bit_strb    = 1'b1;
        @(negedge CLK);
        bit_strb    = 1'b0;
    endtask

    task automatic pulse_start(input logic pe, input logic pt);
        @(negedge CLK);
        start   = 1'b1;
        PAR_EN  = pe;
        PAR_TYP = pt;
        @(negedge CLK);
        start   = 1'b0;
    endtask

    // Sends one frame and returns at the negedge inside the DONE cycle.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pb, input logic exp_valid, input logic exp_err,
                              input bit chk, input string tag);
        pulse_start(pe, pt);
        for (int i = 0; i < W; i++) strobe(d[i]);
        if (pe) strobe(pb);
        if (chk) begin
            check({tag, "_valid"}, 16'(data_valid), 16'(exp_valid));
            check({tag, "_err"},   16'(par_err),    16'(exp_err));
            check({tag, "_data"},  16'(P_DATA),     16'(d));
            check({tag, "_busy"},  16'(busy),       16'h1);
        end
    endtask

    // One cycle after DONE: pulses gone and back in IDLE.
    task automatic post_check(input string tag);
        @(negedge CLK);
        check({tag, "_post_valid"}, 16'(data_valid), 16'h0);
        check({tag, "_post_err"},   16'(par_err),    16'h0);
        check({tag, "_post_busy"},  16'(busy),       16'h0);
    endtask

    initial begin
        logic seen;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // even, correct
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}; // odd, wrong bit
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // parity off
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // odd, correct
        vecs[4] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}; // even, 3 ones
        vecs[5] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // even, wrong bit
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // odd, all zero
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // even, wrong bit

        RST = 1'b1; start = 1'b0; sampled_bit = 1'b0; bit_strb = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
`ifdef UART_RX_PAR_ERR_CNT_EN
        err_cnt_clr = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("rst_data",  16'(P_DATA),     16'h0);
        check("rst_valid", 16'(data_valid), 16'h0);
        check("rst_err",   16'(par_err),    16'h0);
        check("rst_busy",  16'(busy),       16'h0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].par_bit,
                       vecs[i].exp_valid, vecs[i].exp_err, 1'b1, $sformatf("vec%0d", i));
            post_check($sformatf("vec%0d", i));
        end

        // Parity disabled: a stray ninth strobe in IDLE must do nothing.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "nopar");
        post_check("nopar");
        strobe(1'b1);
        check("stray_busy",  16'(busy),       16'h0);
        check("stray_valid", 16'(data_valid), 16'h0);
        check("stray_data",  16'(P_DATA),     16'h3C);

        // Reset mid-frame discards the partial frame silently.
        pulse_start(1'b1, 1'b0);
        strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | data_valid | par_err;
            @(negedge CLK);
        end
        check("midrst_pulse", 16'(seen),   16'h0);
        check("midrst_busy",  16'(busy),   16'h0);
        check("midrst_data",  16'(P_DATA), 16'h0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "after_rst");
        post_check("after_rst");

        // start re-pulsed mid-frame plus PAR_TYP toggle: no restart, latched even.
        pulse_start(1'b1, 1'b0);
        strobe(1'b1); strobe(1'b0);
        @(negedge CLK); start = 1'b1; PAR_TYP = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int i = 2; i < W; i++) strobe(1'b0);
        strobe(1'b1);
        check("restart_valid", 16'(data_valid), 16'h1);
        check("restart_err",   16'(par_err),    16'h0);
        check("restart_data",  16'(P_DATA),     16'h01);
        post_check("restart");

        // start and strobe together in IDLE: strobe dropped.
        @(negedge CLK);
        start = 1'b1; bit_strb = 1'b1; sampled_bit = 1'b1; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        @(negedge CLK);
        start = 1'b0; bit_strb = 1'b0;
        for (int i = 0; i < W; i++) strobe(1'b0);
        strobe(1'b0);
        check("coinc_valid", 16'(data_valid), 16'h1);
        check("coinc_err",   16'(par_err),    16'h0);
        check("coinc_data",  16'(P_DATA),     16'h00);
        post_check("coinc");

`ifdef UART_RX_PAR_ERR_CNT_EN
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        check("cnt_rst", 16'(par_err_cnt), 16'h0);
        for (int i = 0; i < 10; i++) send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "bad");
        @(negedge CLK);
        check("cnt_10", 16'(par_err_cnt), 16'd10);
        for (int i = 0; i < 290; i++) send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "bad");
        @(negedge CLK);
        check("cnt_sat", 16'(par_err_cnt), 16'hFF);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "clr_frame");
        err_cnt_clr = 1'b1;
        @(negedge CLK);
        err_cnt_clr = 1'b0;
        check("cnt_clr", 16'(par_err_cnt), 16'h0);
        @(negedge CLK);
        check("cnt_clr_hold", 16'(par_err_cnt), 16'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
